// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-stage program counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect target trap).
package pc_pkg;

   localparam int DEF_XLEN = 32;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_t;

   // Redirect source reported by the target selector.
   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_BR   = 2'd1;
   localparam logic [1:0] SRC_JAL  = 2'd2;
   localparam logic [1:0] SRC_JALR = 2'd3;

endpackage

// File: rtl/pc_if.sv
// pc_if: redirect/control inputs and fetch/trap outputs of pc_unit.
// The slave modport is the PC unit itself; the master side drives redirects.
interface pc_if
   import pc_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
);
   logic            stall_i;
   logic            branch_res;
   logic [XLEN-1:0] branch_add;
   logic            jal;
   logic [XLEN-1:0] jal_add;
   logic            jalr;
   logic [XLEN-1:0] jalr_add;
   logic            halt_i;
   logic            resume_i;
   logic [XLEN-1:0] address_out;
   logic [XLEN-1:0] pc_plus4;
   logic            fetch_valid;
   logic            trap_valid;
   logic [XLEN-1:0] trap_addr;
   logic [XLEN-1:0] trap_epc;

   modport master (
      output stall_i, branch_res, branch_add, jal, jal_add, jalr, jalr_add,
             halt_i, resume_i,
      input  address_out, pc_plus4, fetch_valid, trap_valid, trap_addr, trap_epc
   );

   modport slave (
      input  stall_i, branch_res, branch_add, jal, jal_add, jalr, jalr_add,
             halt_i, resume_i,
      output address_out, pc_plus4, fetch_valid, trap_valid, trap_addr, trap_epc
   );
endinterface

// File: rtl/pc_target_sel.sv
// pc_target_sel: combinational redirect priority mux (branch > jal > jalr),
// jalr bit-0 clear and target alignment check.
// Optional feature macro: PC_MISALIGN_TRAP_EN.
module pc_target_sel
   import pc_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic            i_branch_res,
   input  logic [XLEN-1:0] i_branch_add,
   input  logic            i_jal,
   input  logic [XLEN-1:0] i_jal_add,
   input  logic            i_jalr,
   input  logic [XLEN-1:0] i_jalr_add,
   output logic [XLEN-1:0] o_target,
   output logic [1:0]      o_src,
   output logic            o_misaligned
);
   logic [XLEN-1:0] w_jalr_tgt;
   logic [XLEN-1:0] w_raw;

   assign w_jalr_tgt = i_jalr_add & ~XLEN'(1);

   // Pick the highest-priority redirect and remember which one won.
   always_comb begin
      w_raw = '0;
      o_src = SRC_NONE;
      if (i_branch_res) begin
         w_raw = i_branch_add;
         o_src = SRC_BR;
      end else if (i_jal) begin
         w_raw = i_jal_add;
         o_src = SRC_JAL;
      end else if (i_jalr) begin
         w_raw = w_jalr_tgt;
         o_src = SRC_JALR;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   // Bit 1 set means the target is not word aligned; the caller traps.
   assign o_target     = w_raw;
   assign o_misaligned = w_raw[1];
`else
   // Without trapping, silently word-align the target.
   assign o_target     = w_raw & ~XLEN'(3);
   assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/pc_unit.sv
// pc_unit: RV32I fetch-stage program counter with reset vector, boot delay,
// stall, halt/resume and optional misaligned-target trap.
// Optional feature macro: PC_MISALIGN_TRAP_EN (when undefined the trap outputs
// are constant zero because the selector never flags a misaligned target).
module pc_unit
   import pc_pkg::*;
#(
   parameter int              XLEN        = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_VEC   = '0,
   parameter logic [XLEN-1:0] TRAP_VEC    = 'h100,
   parameter int              BOOT_CYCLES = 2
) (
   input logic clk,
   input logic rst,
   pc_if.slave bus
);
   localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((BOOT_CYCLES > 0) ? (BOOT_CYCLES - 1) : 0);
   localparam pc_state_t ST_AFTER_RST = (BOOT_CYCLES == 0) ? RUN : BOOT;
   localparam logic      FV_AFTER_RST = (BOOT_CYCLES == 0);

   pc_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0] r_pc;
   logic            r_fetch_valid;
   logic            r_trap_valid;
   logic [XLEN-1:0] r_trap_addr;
   logic [XLEN-1:0] r_trap_epc;

   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_target;
   logic [1:0]      w_src;
   logic            w_misaligned;

   assign w_pc_plus4 = r_pc + XLEN'(4);

   pc_target_sel #(
      .XLEN (XLEN)
   ) u_sel (
      .i_branch_res (bus.branch_res),
      .i_branch_add (bus.branch_add),
      .i_jal        (bus.jal),
      .i_jal_add    (bus.jal_add),
      .i_jalr       (bus.jalr),
      .i_jalr_add   (bus.jalr_add),
      .o_target     (w_target),
      .o_src        (w_src),
      .o_misaligned (w_misaligned)
   );

   // BOOT/RUN/HALT state machine owning the PC and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_AFTER_RST;
         r_cnt         <= '0;
         r_pc          <= RESET_VEC;
         r_fetch_valid <= FV_AFTER_RST;
         r_trap_valid  <= 1'b0;
         r_trap_addr   <= '0;
         r_trap_epc    <= '0;
      end else begin
         r_trap_valid <= 1'b0;
         case (r_state)
            BOOT: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state       <= RUN;
                  r_fetch_valid <= 1'b1;
               end
            end
            RUN: begin
               if (bus.halt_i) begin
                  // The halting instruction retires, so fetch resumes after it.
                  r_pc          <= w_pc_plus4;
                  r_state       <= HALT;
                  r_fetch_valid <= 1'b0;
               end else if (w_src != SRC_NONE) begin
                  // Redirects win over stall.
                  if (w_misaligned) begin
                     r_pc         <= TRAP_VEC;
                     r_trap_valid <= 1'b1;
                     r_trap_addr  <= w_target;
                     r_trap_epc   <= r_pc;
                  end else begin
                     r_pc <= w_target;
                  end
               end else if (!bus.stall_i) begin
                  r_pc <= w_pc_plus4;
               end
            end
            HALT: begin
               if (bus.resume_i) begin
                  r_state       <= RUN;
                  r_fetch_valid <= 1'b1;
               end
            end
            default: begin
               r_state       <= ST_AFTER_RST;
               r_fetch_valid <= FV_AFTER_RST;
            end
         endcase
      end
   end

   assign bus.address_out = r_pc;
   assign bus.pc_plus4    = w_pc_plus4;
   assign bus.fetch_valid = r_fetch_valid;
   assign bus.trap_valid  = r_trap_valid;
   assign bus.trap_addr   = r_trap_addr;
   assign bus.trap_epc    = r_trap_epc;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter generator for the RV32I core's fetch stage. It is the successor to the basic increment/branch/jump PC and adds a configurable reset vector, a post-reset boot delay, pipeline stall, halt/resume, and target-alignment checking. Redirects arrive from the execute stage. The block drives the fetch address, a fetch-valid qualifier and a trap report to the control unit.

## Interface
Parameters:
- XLEN, 32: address width in bits.
- RESET_VEC, 0: PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100: PC value loaded on a misaligned-target trap.
- BOOT_CYCLES, 2: cycles held in BOOT after reset release; 0 is legal.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hold PC this cycle.
- branch_res  in  1  branch taken.
- branch_add  in  XLEN  branch target.
- jal  in  1  JAL redirect.
- jal_add  in  XLEN  JAL target.
- jalr  in  1  JALR redirect.
- jalr_add  in  XLEN  JALR raw target; bit 0 is cleared internally.
- halt_i  in  1  current instruction halts the core.
- resume_i  in  1  leave HALT.
- address_out  out  XLEN  fetch PC.
- pc_plus4  out  XLEN  address_out + 4, combinational.
- fetch_valid  out  1  address_out is a valid fetch.
- trap_valid  out  1  one-cycle misaligned-target pulse.
- trap_addr  out  XLEN  offending target.
- trap_epc  out  XLEN  PC of the instruction that redirected.

## Operation
- The FSM has three states: BOOT, RUN and HALT.
- Reset (any state, highest priority):
  - address_out = RESET_VEC, trap_valid = 0, trap_addr = 0, trap_epc = 0.
  - Boot counter = 0; state = BOOT, or RUN if BOOT_CYCLES = 0.
- BOOT:
  - PC is held, fetch_valid = 0, all inputs are ignored.
  - The counter increments each cycle. When counter = BOOT_CYCLES-1, state becomes RUN.
- RUN: fetch_valid = 1. Next PC is chosen by this priority:
  1. halt_i: PC <= address_out+4, state becomes HALT, redirects are ignored.
  2. Redirect, selected as branch_res > jal > jalr. The selected target is checked (see Configuration).
  3. stall_i: PC is held.
  4. Otherwise PC <= address_out+4.
- A redirect overrides stall_i.
- HALT:
  - fetch_valid = 0, PC is held, redirects and stall_i are ignored.
  - resume_i moves the state to RUN on the next edge with PC unchanged.
- Addition wraps modulo 2^XLEN; 0xFFFF_FFFC + 4 = 0.
- trap_addr and trap_epc hold their values until the next trap or reset.

## Timing
- All outputs except pc_plus4 are registered, and every decision takes effect at the next rising edge.
- fetch_valid and the state change in the same cycle.
- trap_valid is high for exactly the one cycle in which address_out = TRAP_VEC.
- Reset asserted mid-HALT or mid-BOOT takes effect at the next edge and overrides all other inputs.
- Back-to-back redirects on consecutive cycles are each honoured.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A selected target with bit 1 set (after the jalr bit-0 clear) loads TRAP_VEC.
  - The same edge sets trap_valid, trap_addr = the target, and trap_epc = address_out.
- PC_MISALIGN_TRAP_EN undefined:
  - Target bits [1:0] are forced to 0 and the redirect proceeds.
  - trap_valid, trap_addr and trap_epc are tied to 0.

## Structure
- Shared package pc_pkg holds:
  - the state enum (BOOT, RUN, HALT);
  - the XLEN default;
  - redirect-source encoding constants (SRC_NONE, SRC_BR, SRC_JAL, SRC_JALR).
- One combinational sub-module, pc_target_sel:
  - performs the priority mux, the jalr bit-0 clear and the alignment check;
  - outputs the target, the source and a misaligned flag.

## Test plan
- Reset, BOOT_CYCLES=2, RESET_VEC=0x1000 -> address_out=0x1000 with fetch_valid=0 for 2 cycles, then fetch_valid=1; the following PCs are 0x1004, 0x1008.
- branch_res=1 (0x2000), jal=1 (0x3000) and stall_i=1 all in one cycle -> next PC=0x2000.
- stall_i held 3 cycles at PC 0x40 -> PC stays 0x40, then 0x44.
- With the macro defined, jalr_add=0x1003 (cleared to 0x1002) at PC 0x80 -> address_out=0x100, trap_valid pulses once, trap_addr=0x1002, trap_epc=0x80.
- With the macro undefined, the same stimulus -> PC=0x1000 and trap_valid stays 0.
- halt_i at PC 0x50 with jal=1 -> PC=0x54 in HALT, fetch_valid=0. resume_i -> RUN at 0x54. Separately, rst asserted in HALT -> RESET_VEC and BOOT.
